// File: rtl/video_fetch_fifo.sv
// Elastic 8-word video fetch buffer between the DRAM arbiter and the pixel renderer.
// Credits issued reads against free space so in-flight words can never overflow it.
module video_fetch_fifo #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        line_start,
   input  logic        vpix,
   input  logic        int_start,
   input  logic [6:0]  fetch_words,
   output logic        video_go,
   input  logic        video_next,
   input  logic        video_strobe,
   input  logic [15:0] video_data,
   input  logic        pix_rd,
   output logic [15:0] word_out,
   output logic        word_valid,
   output logic        underrun,
   output logic        overrun
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic [1:0]    inflight_q, inflight_d;
   logic [1:0]    discard_q, discard_d;
   logic [6:0]    remain_q, remain_d;
   logic          underrun_q, underrun_d, overrun_q, overrun_d;
   logic [15:0]   mem_q [DEPTH];

   logic          line_init, next_acc, pop, push, strobe_dec, buf_full, buf_empty;
   logic [AW+1:0] occupancy;

   assign buf_full   = (count_q == (AW+1)'(DEPTH));
   assign buf_empty  = (count_q == '0);
   assign occupancy  = (AW+2)'(count_q) + (AW+2)'(inflight_q);
   assign video_go   = (remain_q != '0) && (occupancy < (AW+2)'(DEPTH)) && (inflight_q != 2'd3);
   assign line_init  = line_start & vpix;
   assign next_acc   = video_next & video_go & ~line_init;
   assign pop        = pix_rd & ~buf_empty & ~line_init;
   assign push       = video_strobe & (discard_q == '0) & ~buf_full & ~line_init;
   assign strobe_dec = video_strobe & (inflight_q != '0);

   assign word_valid = ~buf_empty;
   assign word_out   = buf_empty ? 16'h0000 : mem_q[rptr_q];
   assign underrun   = underrun_q;
   assign overrun    = overrun_q;

   // Line init wins over everything; reads still in flight become words to discard.
   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      inflight_d = inflight_q;
      discard_d  = discard_q;
      remain_d   = remain_q;
      if (line_init) begin
         wptr_d     = '0;
         rptr_d     = '0;
         count_d    = '0;
         remain_d   = fetch_words;
         discard_d  = inflight_q - {1'b0, strobe_dec};
         inflight_d = inflight_q - {1'b0, strobe_dec};
      end else begin
         if (next_acc) remain_d = remain_q - 7'd1;
         if (next_acc && !video_strobe) inflight_d = inflight_q + 2'd1;
         else if (!next_acc && strobe_dec) inflight_d = inflight_q - 2'd1;
         if (video_strobe && discard_q != '0) discard_d = discard_q - 2'd1;
         if (push) wptr_d = wptr_q + AW'(1);
         if (pop) rptr_d = rptr_q + AW'(1);
         if (push && !pop) count_d = count_q + (AW+1)'(1);
         else if (pop && !push) count_d = count_q - (AW+1)'(1);
      end
   end

   // Sticky flags: a set in the same cycle as int_start takes precedence.
   always_comb begin
      underrun_d = (underrun_q & ~int_start) | (pix_rd & buf_empty & ~line_init);
      overrun_d  = (overrun_q & ~int_start)
                 | (video_strobe & (discard_q == '0) & buf_full & ~line_init);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         inflight_q <= '0;
         discard_q  <= '0;
         remain_q   <= '0;
         underrun_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         remain_q   <= remain_d;
         underrun_q <= underrun_d;
         overrun_q  <= overrun_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= video_data;
   end

endmodule
